bitwise_logic_pipe: RTL and testbench

- Parametrised, two-stage pipelined bitwise logic unit for the processor datapath.
- Selects one of eight two-operand bitwise functions per transaction and reports a zero flag.
- Uses valid/ready handshakes on input and output, with full backpressure, so it can sit between operand fetch and writeback.
- Carries a tag through the pipe so results can be matched to destination registers.

---
 rtl/bitwise_logic_pipe.sv | 125 ++++++++++++
 tb/tb_bitwise_logic_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides.
// Stage 1 holds the operands; stage 2 holds the result, zero flag and tag that drive out_*.
module bitwise_logic_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       occupancy
);

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_ANDN = 3'd6;
   localparam logic [2:0] OP_ORN  = 3'd7;

   logic             r_s1_valid;
   logic [2:0]       r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_y;
   logic             r_s2_zero;
   logic [TAG_W-1:0] r_s2_tag;

   logic [1:0]       r_occ;

   logic             w_s2_free;
   logic             w_s1_adv;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic [WIDTH-1:0] w_y;

   assign w_s2_free  = !r_s2_valid || out_ready;
   assign w_s1_adv   = r_s1_valid && w_s2_free;
   assign in_ready   = !r_s1_valid || w_s2_free;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_s2_valid && out_ready;

   always_comb begin
      w_y = '0;
      case (r_s1_op)
         OP_AND:  w_y = r_s1_a & r_s1_b;
         OP_OR:   w_y = r_s1_a | r_s1_b;
         OP_XOR:  w_y = r_s1_a ^ r_s1_b;
         OP_NOR:  w_y = ~(r_s1_a | r_s1_b);
         OP_NAND: w_y = ~(r_s1_a & r_s1_b);
         OP_XNOR: w_y = ~(r_s1_a ^ r_s1_b);
         OP_ANDN: w_y = r_s1_a & ~r_s1_b;
         OP_ORN:  w_y = r_s1_a | ~r_s1_b;
         default: w_y = '0;
      endcase
   end

   // Stage 1 reloads whenever it is empty or draining into stage 2 this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_tag   <= '0;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (w_in_xfer) begin
            r_s1_op  <= in_op;
            r_s1_a   <= in_a;
            r_s1_b   <= in_b;
            r_s1_tag <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_y     <= '0;
         r_s2_zero  <= 1'b0;
         r_s2_tag   <= '0;
      end else if (w_s2_free) begin
         r_s2_valid <= r_s1_valid;
         if (w_s1_adv) begin
            r_s2_y    <= w_y;
            r_s2_zero <= ~|w_y;
            r_s2_tag  <= r_s1_tag;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ <= 2'd0;
      end else begin
         case ({w_in_xfer, w_out_xfer})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign out_valid = r_s2_valid;
   assign out_y     = r_s2_y;
   assign out_zero  = r_s2_zero;
   assign out_tag   = r_s2_tag;
   assign occupancy = r_occ;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: directed cases from the test plan plus
// a randomized valid/ready stress run checked against a per-bit truth-table model.
`timescale 1ns/1ps
module tb_bitwise_logic_pipe;

   localparam int W  = 32;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_y;
   logic          out_zero;
   logic [TW-1:0] out_tag;
   logic [1:0]    occupancy;

   bitwise_logic_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_zero(out_zero), .out_tag(out_tag), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]  y;
      logic          z;
      logic [TW-1:0] tag;
   } exp_t;

   int            checks   = 0;
   int            failures = 0;
   exp_t          sb_q[$];
   int            pop_cyc[$];
   int            acc = 0;
   int            del = 0;
   int            cyc = 0;
   logic [W-1:0]  e_y;
   logic          prev_stall = 1'b0;
   logic [W-1:0]  prev_y;
   logic          prev_z;
   logic [TW-1:0] prev_tag;
   exp_t          ex;
   exp_t          tmp;

   // Result bit = truth table indexed by {a_bit, b_bit}.
   function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic [3:0]   tt;
      logic [W-1:0] r;
      case (op)
         3'd0:    tt = 4'b1000;
         3'd1:    tt = 4'b1110;
         3'd2:    tt = 4'b0110;
         3'd3:    tt = 4'b0001;
         3'd4:    tt = 4'b0111;
         3'd5:    tt = 4'b1001;
         3'd6:    tt = 4'b0100;
         default: tt = 4'b1101;
      endcase
      for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: accounts input/output transfers, pops the scoreboard, checks stability under stall.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         acc = 0;
         del = 0;
         prev_stall = 1'b0;
      end else begin
         check("occupancy", 64'(occupancy), 64'(acc - del));
         if (prev_stall) begin
            check("stall_y", 64'(out_y), 64'(prev_y));
            check("stall_zero", 64'(out_zero), 64'(prev_z));
            check("stall_tag", 64'(out_tag), 64'(prev_tag));
         end
         if (in_valid && in_ready) begin
            tmp.y   = e_y;
            tmp.z   = ~|e_y;
            tmp.tag = in_tag;
            sb_q.push_back(tmp);
            acc++;
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual_tag=%0h required=none", out_tag);
            end else begin
               ex = sb_q.pop_front();
               check("out_y", 64'(out_y), 64'(ex.y));
               check("out_zero", 64'(out_zero), 64'(ex.z));
               check("out_tag", 64'(out_tag), 64'(ex.tag));
            end
            del++;
            pop_cyc.push_back(cyc);
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = out_y;
         prev_z     = out_zero;
         prev_tag   = out_tag;
      end
   end

   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [W-1:0] ey);
      bit done = 1'b0;
      int n = 0;
      in_valid = 1'b1;
      in_op = op; in_a = a; in_b = b; in_tag = tag; e_y = ey;
      while (!done && n < 50) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0h", tag);
      end
   endtask

   task automatic send_rand(input logic [TW-1:0] tag);
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      send(op, a, b, tag, ref_model(op, a, b));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [W-1:0] ops_exp [8];
   logic [W-1:0] held_y;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ops_exp = '{32'hA500_0A0A, 32'hFFA5_5F5F, 32'h5AA5_5555, 32'h005A_A0A0,
                  32'h5AFF_F5F5, 32'hA55A_AAAA, 32'h00A5_5050, 32'hA5FF_FAFA};
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_a = '0; in_b = '0; in_tag = '0; e_y = '0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_out_y", 64'(out_y), 64'd0);
      check("rst_out_zero", 64'(out_zero), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      idle(2);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Single transaction latency
      send(3'd1, 32'hF0F0_0000, 32'h0F0F_0000, 4'd3, 32'hFFFF_0000);
      check("lat_c1_occ", 64'(occupancy), 64'd1);
      check("lat_c1_valid", 64'(out_valid), 64'd0);
      idle(1);
      check("lat_c2_valid", 64'(out_valid), 64'd1);
      check("lat_c2_occ", 64'(occupancy), 64'd1);
      check("lat_c2_y", 64'(out_y), 64'hFFFF_0000);
      check("lat_c2_tag", 64'(out_tag), 64'd3);
      idle(1);
      check("lat_c3_valid", 64'(out_valid), 64'd0);
      check("lat_c3_occ", 64'(occupancy), 64'd0);

      // All ops streamed back-to-back
      idle(2);
      pop_cyc.delete();
      for (int i = 0; i < 8; i++)
         send(3'(i), 32'hA5A5_5A5A, 32'hFF00_0F0F, 4'(i), ops_exp[i]);
      idle(4);
      check("stream_count", 64'(pop_cyc.size()), 64'd8);
      if (pop_cyc.size() == 8)
         check("stream_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

      // Zero flag
      send(3'd0, 32'h0000_FFFF, 32'hFFFF_0000, 4'd5, 32'h0);
      send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'h0);
      idle(4);

      // Backpressure
      out_ready = 1'b0;
      send_rand(4'd1);
      send_rand(4'd2);
      in_valid = 1'b1; in_tag = 4'd3;
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_occupancy", 64'(occupancy), 64'd2);
      check("bp_head_tag", 64'(out_tag), 64'd1);
      held_y = out_y;
      @(negedge clk);
      check("bp_in_ready_hold", 64'(in_ready), 64'd0);
      check("bp_y_stable", 64'(out_y), 64'(held_y));
      @(posedge clk);
      #1;
      pop_cyc.delete();
      out_ready = 1'b1;
      send_rand(4'd3);
      idle(3);
      check("bp_drain_count", 64'(pop_cyc.size()), 64'd3);
      if (pop_cyc.size() == 3)
         check("bp_drain_span", 64'(pop_cyc[2] - pop_cyc[0]), 64'd2);

      // Mid-flight reset with a full pipe
      out_ready = 1'b0;
      send_rand(4'd7);
      send_rand(4'd8);
      #2;
      rst = 1'b1;
      #1;
      check("mrst_out_valid", 64'(out_valid), 64'd0);
      check("mrst_occupancy", 64'(occupancy), 64'd0);
      check("mrst_out_y", 64'(out_y), 64'd0);
      check("mrst_out_tag", 64'(out_tag), 64'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      out_ready = 1'b1;
      idle(5);
      check("mrst_no_stale", 64'(out_valid), 64'd0);
      check("mrst_occ_after", 64'(occupancy), 64'd0);

      // Random stress
      for (int n = 0; n < 10000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_op     = 3'($urandom_range(0, 7));
         in_a      = $urandom;
         in_b      = $urandom;
         if ($urandom_range(0, 15) == 0) in_b = in_a;
         in_tag    = 4'($urandom);
         e_y       = ref_model(in_op, in_a, in_b);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 20 && (sb_q.size() != 0 || out_valid); n++) idle(1);
      check("final_sb_empty", 64'(sb_q.size()), 64'd0);
      check("final_occupancy", 64'(occupancy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
